// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad initiator.
// Drives one active-low column at a time, samples the active-low rows through
// a 2-FF synchronizer, debounces a single key press and reports its code.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   keypad column drive, active-low one-hot
//   key_value  last accepted key code (row_index*4 + col_index)
//   key_valid  one-cycle pulse on acceptance of a new key
//   key_held   high from acceptance until the release is accepted
module keypad_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    // Returns {valid, row_index}; valid only when exactly one row is low.
    function automatic logic [2:0] decode_row(input logic [3:0] rs);
        logic [2:0] res;
        case (rs)
            4'b1110: res = 3'b100;
            4'b1101: res = 3'b101;
            4'b1011: res = 3'b110;
            4'b0111: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    state_t        state_r, state_s;
    logic [3:0]    sync1_r, sync2_r;
    logic [DW-1:0] dwell_r, dwell_s;
    logic [1:0]    col_idx_r, col_idx_s;
    logic [3:0]    col_r, col_s;
    logic [1:0]    cand_row_r, cand_row_s;
    logic [CW-1:0] deb_cnt_r, deb_cnt_s;
    logic [CW-1:0] rel_cnt_r, rel_cnt_s;
    logic [3:0]    key_value_r, key_value_s;
    logic          key_valid_r, key_valid_s;
    logic          key_held_r, key_held_s;
    logic          sample_s;
    logic [2:0]    dec_s;
    logic          single_s;
    logic [1:0]    row_idx_s;

    assign sample_s  = (dwell_r == DWELL_LAST);
    assign dec_s     = decode_row(sync2_r);
    assign single_s  = dec_s[2];
    assign row_idx_s = dec_s[1:0];

    assign col       = col_r;
    assign key_value = key_value_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

    // Synchronizer, counters, FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r     <= 4'b1111;
            sync2_r     <= 4'b1111;
            state_r     <= ST_SCAN;
            dwell_r     <= {DW{1'b0}};
            col_idx_r   <= 2'd0;
            col_r       <= 4'b1110;
            cand_row_r  <= 2'd0;
            deb_cnt_r   <= {CW{1'b0}};
            rel_cnt_r   <= {CW{1'b0}};
            key_value_r <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            sync1_r     <= row;
            sync2_r     <= sync1_r;
            state_r     <= state_s;
            dwell_r     <= dwell_s;
            col_idx_r   <= col_idx_s;
            col_r       <= col_s;
            cand_row_r  <= cand_row_s;
            deb_cnt_r   <= deb_cnt_s;
            rel_cnt_r   <= rel_cnt_s;
            key_value_r <= key_value_s;
            key_valid_r <= key_valid_s;
            key_held_r  <= key_held_s;
        end
    end

    // Next-state logic: all decisions are taken only at the dwell sample point,
    // which is also the only moment the column may change.
    always_comb begin
        state_s     = state_r;
        col_idx_s   = col_idx_r;
        cand_row_s  = cand_row_r;
        deb_cnt_s   = deb_cnt_r;
        rel_cnt_s   = rel_cnt_r;
        key_value_s = key_value_r;
        key_valid_s = 1'b0;
        key_held_s  = key_held_r;

        if (sample_s) begin
            dwell_s = {DW{1'b0}};
            case (state_r)
                ST_SCAN: begin
                    if (single_s) begin
                        cand_row_s = row_idx_s;
                        if (DEBOUNCE == 1) begin
                            state_s     = ST_PRESSED;
                            key_value_s = {row_idx_s, col_idx_r};
                            key_valid_s = 1'b1;
                            key_held_s  = 1'b1;
                            rel_cnt_s   = {CW{1'b0}};
                        end else begin
                            state_s   = ST_DEBOUNCE;
                            deb_cnt_s = CW'(1);
                        end
                    end else begin
                        col_idx_s = col_idx_r + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (single_s && (row_idx_s == cand_row_r)) begin
                        if (deb_cnt_r == CNT_LAST) begin
                            state_s     = ST_PRESSED;
                            key_value_s = {cand_row_r, col_idx_r};
                            key_valid_s = 1'b1;
                            key_held_s  = 1'b1;
                            deb_cnt_s   = {CW{1'b0}};
                            rel_cnt_s   = {CW{1'b0}};
                        end else begin
                            deb_cnt_s = deb_cnt_r + CW'(1);
                        end
                    end else begin
                        state_s   = ST_SCAN;
                        deb_cnt_s = {CW{1'b0}};
                        col_idx_s = col_idx_r + 2'd1;
                    end
                end
                ST_PRESSED: begin
                    if (sync2_r == 4'b1111) begin
                        if (rel_cnt_r == CNT_LAST) begin
                            state_s    = ST_SCAN;
                            key_held_s = 1'b0;
                            rel_cnt_s  = {CW{1'b0}};
                            col_idx_s  = col_idx_r + 2'd1;
                        end else begin
                            rel_cnt_s = rel_cnt_r + CW'(1);
                        end
                    end else begin
                        rel_cnt_s = {CW{1'b0}};
                    end
                end
                default: begin
                    state_s    = ST_SCAN;
                    deb_cnt_s  = {CW{1'b0}};
                    rel_cnt_s  = {CW{1'b0}};
                    key_held_s = 1'b0;
                end
            endcase
        end else begin
            dwell_s = dwell_r + DW'(1);
        end

        col_s = ~(4'b0001 << col_idx_s);
    end

endmodule
